// File: rtl/vx_dot8_pkg.sv
// Shared types and arithmetic helpers for the packed-byte dot-product PE.
// Default widths match the parameters of vx_alu_dot8 and must be kept in step with them.
package vx_dot8_pkg;

  localparam int DOT8_BYTES      = 4;
  localparam int DOT8_PROD_W     = 17;
  localparam int DOT8_SUM_W      = 19;
  localparam int DOT8_PROD_VEC_W = DOT8_BYTES * DOT8_PROD_W;

  localparam int DOT8_NUM_LANES  = 4;
  localparam int DOT8_XLEN       = 32;
  localparam int DOT8_UUID_W     = 44;
  localparam int DOT8_NW_W       = 2;
  localparam int DOT8_PC_W       = 30;
  localparam int DOT8_NR_W       = 6;
  localparam int DOT8_PID_W      = 1;

  typedef struct packed {
    logic [DOT8_UUID_W-1:0]    uuid;
    logic [DOT8_NW_W-1:0]      wid;
    logic [DOT8_NUM_LANES-1:0] tmask;
    logic [DOT8_PC_W-1:0]      pc;
    logic                      wb;
    logic [DOT8_NR_W-1:0]      rd;
    logic [DOT8_PID_W-1:0]     pid;
    logic                      sop;
    logic                      eop;
  } dot8_sideband_t;

  // Each byte is widened to 9 bits so one signed multiplier serves both signed and unsigned modes.
  function automatic logic [DOT8_PROD_VEC_W-1:0] dot8_products(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        is_unsigned
  );
    logic signed [8:0]  ea;
    logic signed [8:0]  eb;
    logic signed [17:0] full;
    logic [DOT8_PROD_VEC_W-1:0] p;
    p = '0;
    for (int i = 0; i < DOT8_BYTES; i++) begin
      ea   = {(~is_unsigned) & a[8*i+7], a[8*i +: 8]};
      eb   = {(~is_unsigned) & b[8*i+7], b[8*i +: 8]};
      full = 18'(ea) * 18'(eb);
      p[i*DOT8_PROD_W +: DOT8_PROD_W] = full[DOT8_PROD_W-1:0];
    end
    return p;
  endfunction

  function automatic logic signed [DOT8_SUM_W-1:0] dot8_sum(
    input logic [DOT8_PROD_VEC_W-1:0] p
  );
    logic [DOT8_SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DOT8_BYTES; i++) begin
      acc = acc + {{(DOT8_SUM_W-DOT8_PROD_W){p[i*DOT8_PROD_W+DOT8_PROD_W-1]}},
                   p[i*DOT8_PROD_W +: DOT8_PROD_W]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/vx_dot8_lane.sv
// One lane of the dot-product datapath: the product half feeds the S1 registers,
// the sum half consumes them, so the top can place a register between the two.
module vx_dot8_lane
  import vx_dot8_pkg::*;
(
  input  logic [31:0]                rs1,
  input  logic [31:0]                rs2,
  input  logic                       is_unsigned,
  output logic [DOT8_PROD_VEC_W-1:0] prod,
  input  logic [DOT8_PROD_VEC_W-1:0] prod_reg,
  input  logic                       active,
  output logic [31:0]                result
);

  logic signed [DOT8_SUM_W-1:0] sum_s;

  assign prod   = dot8_products(rs1, rs2, is_unsigned);
  assign sum_s  = dot8_sum(prod_reg);
  assign result = active ? {{(32-DOT8_SUM_W){sum_s[DOT8_SUM_W-1]}}, sum_s} : 32'd0;

endmodule

// File: rtl/vx_alu_dot8.sv
// Packed-byte dot-product PE: two-stage elastic pipeline (products, then sum)
// with valid/ready backpressure and sideband carried alongside the data.
module vx_alu_dot8
  import vx_dot8_pkg::*;
#(
  parameter int NUM_LANES  = DOT8_NUM_LANES,
  parameter int XLEN       = DOT8_XLEN,
  parameter int UUID_WIDTH = DOT8_UUID_W,
  parameter int NW_WIDTH   = DOT8_NW_W,
  parameter int PC_BITS    = DOT8_PC_W,
  parameter int NR_BITS    = DOT8_NR_W,
  parameter int PID_WIDTH  = DOT8_PID_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [UUID_WIDTH-1:0]     in_uuid,
  input  logic [NW_WIDTH-1:0]       in_wid,
  input  logic [NUM_LANES-1:0]      in_tmask,
  input  logic [PC_BITS-1:0]        in_pc,
  input  logic                      in_wb,
  input  logic [NR_BITS-1:0]        in_rd,
  input  logic                      in_is_unsigned,
  input  logic [NUM_LANES*XLEN-1:0] in_rs1_data,
  input  logic [NUM_LANES*XLEN-1:0] in_rs2_data,
  input  logic [PID_WIDTH-1:0]      in_pid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [UUID_WIDTH-1:0]     out_uuid,
  output logic [NW_WIDTH-1:0]       out_wid,
  output logic [NUM_LANES-1:0]      out_tmask,
  output logic [PC_BITS-1:0]        out_pc,
  output logic                      out_wb,
  output logic [NR_BITS-1:0]        out_rd,
  output logic [NUM_LANES*XLEN-1:0] out_data,
  output logic [PID_WIDTH-1:0]      out_pid,
  output logic                      out_sop,
  output logic                      out_eop
);

  localparam int PW = DOT8_PROD_VEC_W;

  logic                      adv1_s;
  logic                      adv2_s;
  logic                      s1_valid_r;
  logic                      s2_valid_r;
  dot8_sideband_t            in_sb_s;
  dot8_sideband_t            s1_sb_r;
  dot8_sideband_t            s2_sb_r;
  logic [NUM_LANES*PW-1:0]   prod_s;
  logic [NUM_LANES*PW-1:0]   s1_prod_r;
  logic [NUM_LANES*XLEN-1:0] result_s;
  logic [NUM_LANES*XLEN-1:0] s2_data_r;

  // A stage may load when it is empty or the stage after it is moving.
  assign adv2_s   = ~s2_valid_r | out_ready;
  assign adv1_s   = ~s1_valid_r | adv2_s;
  assign in_ready = adv1_s;

  assign in_sb_s = '{uuid: in_uuid, wid: in_wid, tmask: in_tmask, pc: in_pc, wb: in_wb,
                     rd: in_rd, pid: in_pid, sop: in_sop, eop: in_eop};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vx_dot8_lane u_lane (
      .rs1         (in_rs1_data[l*XLEN +: 32]),
      .rs2         (in_rs2_data[l*XLEN +: 32]),
      .is_unsigned (in_is_unsigned),
      .prod        (prod_s[l*PW +: PW]),
      .prod_reg    (s1_prod_r[l*PW +: PW]),
      .active      (s1_sb_r.tmask[l]),
      .result      (result_s[l*XLEN +: XLEN])
    );
  end

  // Stage 1: byte products and sideband of the accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_sb_r    <= '0;
      s1_prod_r  <= '0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sb_r   <= in_sb_s;
        s1_prod_r <= prod_s;
      end
    end
  end

  // Stage 2: lane sums, which drive the commit outputs directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r <= 1'b0;
      s2_sb_r    <= '0;
      s2_data_r  <= '0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sb_r   <= s1_sb_r;
        s2_data_r <= result_s;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_uuid  = s2_sb_r.uuid;
  assign out_wid   = s2_sb_r.wid;
  assign out_tmask = s2_sb_r.tmask;
  assign out_pc    = s2_sb_r.pc;
  assign out_wb    = s2_sb_r.wb;
  assign out_rd    = s2_sb_r.rd;
  assign out_pid   = s2_sb_r.pid;
  assign out_sop   = s2_sb_r.sop;
  assign out_eop   = s2_sb_r.eop;
  assign out_data  = s2_data_r;

endmodule

// File: tb/tb_vx_alu_dot8.sv
// Directed bench for vx_alu_dot8: arithmetic vector table plus hand-built
// backpressure, streaming and asynchronous-reset sequences.
module tb_vx_alu_dot8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [43:0]  in_uuid;
  logic [1:0]   in_wid;
  logic [3:0]   in_tmask;
  logic [29:0]  in_pc;
  logic         in_wb;
  logic [5:0]   in_rd;
  logic         in_is_unsigned;
  logic [127:0] in_rs1_data;
  logic [127:0] in_rs2_data;
  logic [0:0]   in_pid;
  logic         in_sop;
  logic         in_eop;
  logic         out_valid;
  logic         out_ready;
  logic [43:0]  out_uuid;
  logic [1:0]   out_wid;
  logic [3:0]   out_tmask;
  logic [29:0]  out_pc;
  logic         out_wb;
  logic [5:0]   out_rd;
  logic [127:0] out_data;
  logic [0:0]   out_pid;
  logic         out_sop;
  logic         out_eop;

  int n_pass  = 0;
  int n_total = 0;

  vx_alu_dot8 dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_pc(in_pc), .in_wb(in_wb), .in_rd(in_rd),
    .in_is_unsigned(in_is_unsigned), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wid(out_wid),
    .out_tmask(out_tmask), .out_pc(out_pc), .out_wb(out_wb), .out_rd(out_rd),
    .out_data(out_data), .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] rs1;
    logic [127:0] rs2;
    logic         uns;
    logic [3:0]   tmask;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_uuid = 44'd0; in_wid = 2'd0; in_tmask = 4'd0; in_pc = 30'd0;
    in_wb = 1'b0; in_rd = 6'd0; in_is_unsigned = 1'b0; in_rs1_data = 128'd0;
    in_rs2_data = 128'd0; in_pid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  function automatic logic [45:0] stream_sb(input int k);
    logic [3:0] km;
    km = 4'(k);
    return {km[1:0], km, 30'(k*4 + 256), km[0], 6'(k + 1), km[1], k == 0, k == 15};
  endfunction

  function automatic logic [127:0] stream_data(input int k);
    logic [127:0] d;
    logic [3:0]   km;
    km = 4'(k);
    d  = 128'd0;
    for (int l = 0; l < 4; l++) d[l*32 +: 32] = km[l] ? 32'(4*k) : 32'd0;
    return d;
  endfunction

  task automatic drive_stream(input int k);
    logic [3:0] km;
    km = 4'(k);
    in_valid = 1'b1; in_uuid = 44'(200 + k); in_wid = km[1:0]; in_tmask = km;
    in_pc = 30'(k*4 + 256); in_wb = km[0]; in_rd = 6'(k + 1); in_pid = km[1];
    in_sop = (k == 0); in_eop = (k == 15); in_is_unsigned = 1'b0;
    in_rs1_data = {4{32'h01010101}}; in_rs2_data = {4{{4{8'(k)}}}};
  endtask

  initial begin
    int acc;
    int pops;
    logic hold;
    logic [43:0] hold_uuid;
    logic [127:0] hold_data;

    vecs[0] = '{{32'h01010101, 32'h01010101, 32'h01010101, 32'h04030201}, {4{32'h01010101}},
                1'b0, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h0000000A}};
    vecs[1] = '{{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80808080, 32'h80808080},
                {32'h01010101, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'h80808080},
                1'b0, 4'b1111, {32'hFFFFFFFC, 32'h00000004, 32'hFFFF0200, 32'h00010000}};
    vecs[2] = '{{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80808080, 32'h80808080},
                {32'h01010101, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'h80808080},
                1'b1, 4'b1111, {32'h000003FC, 32'h0003F804, 32'h0000FE00, 32'h00010000}};
    vecs[3] = '{{32'h7F7F7F7F, 32'hFFFFFFFF, 32'h04030201, 32'hFFFFFFFF},
                {32'h7F7F7F7F, 32'hFFFFFFFF, 32'h04030201, 32'hFFFFFFFF},
                1'b0, 4'b1010, {32'h0000FC04, 32'h0, 32'h0000001E, 32'h0}};
    vecs[4] = '{{4{32'h7F80FF01}}, {4{32'h02FE0380}}, 1'b0, 4'b1111, {4{32'h0000017B}}};
    vecs[5] = '{{4{32'h7F80FF01}}, {4{32'h02FE0380}}, 1'b1, 4'b1111, {4{32'h0000837B}}};

    idle();
    out_ready = 1'b1;
    reset_n   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_data", out_data, 128'd0);
    check("reset_out_uuid", out_uuid, 44'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_uuid = 44'(100 + i); in_rs1_data = vecs[i].rs1;
      in_rs2_data = vecs[i].rs2; in_is_unsigned = vecs[i].uns; in_tmask = vecs[i].tmask;
      @(negedge clk);
      idle();
      #1;
      check("vec_early_valid", out_valid, 1'b0);
      @(negedge clk);
      #1;
      check("vec_valid", out_valid, 1'b1);
      check("vec_uuid", out_uuid, 44'(100 + i));
      check("vec_tmask", out_tmask, vecs[i].tmask);
      check("vec_data", out_data, vecs[i].exp);
    end

    repeat (3) @(negedge clk);
    acc = 0; pops = 0; hold = 1'b0; hold_uuid = 44'd0; hold_data = 128'd0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      if (acc < 5) begin
        in_valid = 1'b1; in_uuid = 44'(acc + 1); in_tmask = 4'b1111; in_is_unsigned = 1'b0;
        in_rs1_data = {4{32'(acc + 1)}}; in_rs2_data = {4{32'd3}};
      end else begin
        idle();
      end
      #1;
      if (hold) begin
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_uuid", out_uuid, hold_uuid);
        check("bp_hold_data", out_data, hold_data);
      end
      if (c == 3) check("bp_full_in_ready", in_ready, 1'b0);
      if (c == 7) check("bp_resume_in_ready", in_ready, 1'b1);
      if (out_valid && out_ready) begin
        pops++;
        check("bp_order_uuid", out_uuid, 44'(pops));
        check("bp_order_data", out_data, {4{32'(3*pops)}});
      end
      hold = out_valid && !out_ready; hold_uuid = out_uuid; hold_data = out_data;
      if (in_valid && in_ready) acc++;
    end
    check("bp_pop_count", 128'(pops), 128'd5);
    check("bp_accept_count", 128'(acc), 128'd5);

    repeat (3) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c < 16) drive_stream(c);
      else idle();
      #1;
      if (c >= 2 && c < 18) begin
        check("stream_valid", out_valid, 1'b1);
        check("stream_uuid", out_uuid, 44'(200 + c - 2));
        check("stream_sideband", {out_wid, out_tmask, out_pc, out_wb, out_rd, out_pid, out_sop, out_eop},
              stream_sb(c - 2));
        check("stream_data", out_data, stream_data(c - 2));
      end else begin
        check("stream_idle_valid", out_valid, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    in_valid = 1'b1; in_uuid = 44'd300; in_tmask = 4'b1111;
    in_rs1_data = {4{32'h01010101}}; in_rs2_data = {4{32'h01010101}};
    @(negedge clk);
    in_uuid = 44'd301;
    @(posedge clk);
    #1;
    check("rst_pre_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    idle();
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_in_ready", in_ready, 1'b1);
    check("rst_async_uuid", out_uuid, 44'd0);
    check("rst_async_data", out_data, 128'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_release_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("rst_no_stale_valid", out_valid, 1'b0);
    end

    @(negedge clk);
    in_valid = 1'b1; in_uuid = 44'd400; in_rs1_data = vecs[1].rs1; in_rs2_data = vecs[1].rs2;
    in_is_unsigned = vecs[1].uns; in_tmask = vecs[1].tmask;
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    check("rst_recover_valid", out_valid, 1'b1);
    check("rst_recover_data", out_data, vecs[1].exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
